regset_ctrl: RTL and testbench

Access controller in front of the 64-entry, 2-read/1-write BRAM register set. The BRAM has no reset, so after reset this block clears every entry. It arbitrates between the CPU pipeline and a debug port that reads and writes single registers. It also forwards same-cycle write data over the BRAM's read-old-on-collision behaviour, so the CPU always sees fresh values. It sits between the RudolV pipeline and the register set, and both connect only through it.

---
 rtl/regset_ctrl_pkg.sv | 6 +
 rtl/regset_fwd.sv | 24 ++
 rtl/regset_ctrl.sv | 98 +++++++++
 tb/tb_regset_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regset_ctrl_pkg.sv
// regset_ctrl_pkg: shared sizes and controller state encoding for the register-set access controller
package regset_ctrl_pkg;
  localparam int REG_ADDR_W = 6;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {CLEAR, RUN, DBG_ACC, DBG_RSP} state_t;
endpackage

// File: rtl/regset_fwd.sv
// regset_fwd: one read port's write-collision bypass; ports clk/rst, write side we/wa/wd, read addr ra, BRAM data rs_rd in, forwarded rd out
module regset_fwd
  import regset_ctrl_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rs_rd,
  output logic [DATA_W-1:0] rd
);
  logic              fwd;
  logic [DATA_W-1:0] fwd_data;
  always_ff @(posedge clk) begin
    fwd <= rst ? 1'b0 : (we && wa == ra && wa != '0);
    fwd_data <= wd;
  end
  assign rd = fwd ? fwd_data : rs_rd;
endmodule

// File: rtl/regset_ctrl.sv
// regset_ctrl: clears the BRAM register set after reset, arbitrates CPU vs debug access, forwards same-cycle writes; ports cpu_* pipeline side, dbg_* debug side, rs_* BRAM side, init_done
module regset_ctrl
  import regset_ctrl_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = XLEN,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_wa,
  input  logic [DATA_W-1:0] cpu_wd,
  input  logic [ADDR_W-1:0] cpu_ra1,
  input  logic [ADDR_W-1:0] cpu_ra2,
  output logic [DATA_W-1:0] cpu_rd1,
  output logic [DATA_W-1:0] cpu_rd2,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              init_done,
  output logic              rs_we,
  output logic [ADDR_W-1:0] rs_wa,
  output logic [DATA_W-1:0] rs_wd,
  output logic [ADDR_W-1:0] rs_ra1,
  output logic [ADDR_W-1:0] rs_ra2,
  input  logic [DATA_W-1:0] rs_rd1,
  input  logic [DATA_W-1:0] rs_rd2
);
  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt, cap1, cap2;
  logic              fwd_we;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
      init_done <= 1'b0;
    end else begin
      state <= state_n;
      if (state == CLEAR) cnt <= cnt + 1'b1;
      init_done <= state_n != CLEAR;
    end
  end
  always_ff @(posedge clk)
    if (state == RUN) begin
      cap1 <= cpu_ra1;
      cap2 <= cpu_ra2;
    end
  always_comb begin
    state_n = state;
    rs_we = 1'b0;
    rs_wa = cpu_wa;
    rs_wd = cpu_wd;
    rs_ra1 = cpu_ra1;
    rs_ra2 = cpu_ra2;
    case (state)
      CLEAR: begin
        rs_we = CLEAR_ON_RESET;
        rs_wa = cnt;
        rs_wd = '0;
        state_n = (!CLEAR_ON_RESET || cnt == '1) ? RUN : CLEAR;
      end
      RUN: begin
        rs_we = cpu_we && cpu_wa != '0;
        state_n = dbg_req ? DBG_ACC : RUN;
      end
      DBG_ACC: begin
        rs_we = dbg_we && dbg_addr != '0;
        rs_wa = dbg_addr;
        rs_wd = dbg_wdata;
        rs_ra1 = dbg_addr;
        rs_ra2 = cap2;
        state_n = DBG_RSP;
      end
      default: begin
        rs_ra1 = cap1;
        rs_ra2 = cap2;
        state_n = RUN;
      end
    endcase
  end
  assign cpu_stall = state != RUN;
  assign dbg_ack = state == DBG_RSP;
  assign dbg_rdata = dbg_ack ? cpu_rd1 : '0;
  assign fwd_we = rs_we && state != DBG_ACC;
  regset_fwd #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd1 (
    .clk(clk), .rst(rst), .we(fwd_we), .wa(rs_wa), .wd(rs_wd),
    .ra(rs_ra1), .rs_rd(rs_rd1), .rd(cpu_rd1)
  );
  regset_fwd #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd2 (
    .clk(clk), .rst(rst), .we(fwd_we), .wa(rs_wa), .wd(rs_wd),
    .ra(rs_ra2), .rs_rd(rs_rd2), .rd(cpu_rd2)
  );
endmodule

// File: tb/tb_regset_ctrl.sv
// tb_regset_ctrl: directed self-checking bench for regset_ctrl with a read-old-on-collision BRAM model
module tb_regset_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_we = 1'b0;
  logic [5:0]  cpu_wa = '0;
  logic [31:0] cpu_wd = '0;
  logic [5:0]  cpu_ra1 = '0;
  logic [5:0]  cpu_ra2 = '0;
  logic [31:0] cpu_rd1, cpu_rd2;
  logic        cpu_stall;
  logic        dbg_req = 1'b0;
  logic        dbg_we = 1'b0;
  logic [5:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        init_done;
  logic        rs_we;
  logic [5:0]  rs_wa, rs_ra1, rs_ra2;
  logic [31:0] rs_wd, rs_rd1, rs_rd2;
  logic [31:0] mem [64];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rs_rd1 <= mem[rs_ra1];
    rs_rd2 <= mem[rs_ra2];
    if (rs_we) mem[rs_wa] <= rs_wd;
  end

  regset_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_we(cpu_we), .cpu_wa(cpu_wa), .cpu_wd(cpu_wd),
    .cpu_ra1(cpu_ra1), .cpu_ra2(cpu_ra2), .cpu_rd1(cpu_rd1), .cpu_rd2(cpu_rd2),
    .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .init_done(init_done),
    .rs_we(rs_we), .rs_wa(rs_wa), .rs_wd(rs_wd), .rs_ra1(rs_ra1), .rs_ra2(rs_ra2),
    .rs_rd1(rs_rd1), .rs_rd2(rs_rd2)
  );

  task automatic run_clear(input string tag);
    for (int i = 0; i < 64; i++) begin
      #1;
      checks++;
      if (rs_we !== 1'b1 || rs_wa !== 6'(i) || rs_wd !== 32'h0 || init_done !== 1'b0 || cpu_stall !== 1'b1 || dbg_ack !== 1'b0) begin
        errors++;
        $display("FAIL %s clear[%0d]: got we=%b wa=%0d wd=%h done=%b stall=%b ack=%b, expected we=1 wa=%0d wd=0 done=0 stall=1 ack=0",
                 tag, i, rs_we, rs_wa, rs_wd, init_done, cpu_stall, dbg_ack, i);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (init_done !== 1'b1 || cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL %s clear_end: got done=%b stall=%b, expected done=1 stall=0", tag, init_done, cpu_stall);
    end
  endtask

  task automatic cpu_write(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    cpu_we = 1'b1;
    cpu_wa = a;
    cpu_wd = d;
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    #1;
    checks++;
    if (init_done !== 1'b0 || cpu_stall !== 1'b1 || dbg_ack !== 1'b0 || dbg_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset: got done=%b stall=%b ack=%b rdata=%h, expected done=0 stall=1 ack=0 rdata=0",
               init_done, cpu_stall, dbg_ack, dbg_rdata);
    end
    rst = 1'b0;
    run_clear("reset");
  endtask

  task automatic test_forward;
    @(negedge clk);
    cpu_we = 1'b1; cpu_wa = 6'd5; cpu_wd = 32'hDEADBEEF; cpu_ra1 = 6'd5; cpu_ra2 = 6'd5;
    #1;
    checks++;
    if (rs_we !== 1'b1 || rs_wa !== 6'd5 || rs_wd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL fwd_write: got we=%b wa=%0d wd=%h, expected we=1 wa=5 wd=deadbeef", rs_we, rs_wa, rs_wd);
    end
    @(negedge clk);
    cpu_we = 1'b0;
    #1;
    checks++;
    if (cpu_rd1 !== 32'hDEADBEEF || cpu_rd2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL fwd_same_cycle: got rd1=%h rd2=%h, expected deadbeef", cpu_rd1, cpu_rd2);
    end
    @(negedge clk);
    #1;
    checks++;
    if (cpu_rd1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL fwd_stored: got rd1=%h, expected deadbeef", cpu_rd1);
    end
  endtask

  task automatic test_x0;
    @(negedge clk);
    cpu_we = 1'b1; cpu_wa = 6'd0; cpu_wd = 32'h12345678; cpu_ra1 = 6'd0; cpu_ra2 = 6'd0;
    #1;
    checks++;
    if (rs_we !== 1'b0) begin
      errors++;
      $display("FAIL x0_suppress: got rs_we=%b, expected 0", rs_we);
    end
    @(negedge clk);
    cpu_we = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (cpu_rd1 !== 32'h0 || cpu_rd2 !== 32'h0) begin
      errors++;
      $display("FAIL x0_read: got rd1=%h rd2=%h, expected 0", cpu_rd1, cpu_rd2);
    end
  endtask

  task automatic test_dbg_read;
    cpu_write(6'd3, 32'h33);
    cpu_write(6'd4, 32'h44);
    cpu_write(6'd7, 32'hA5A5A5A5);
    @(negedge clk);
    cpu_ra1 = 6'd3; cpu_ra2 = 6'd4; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd7;
    #1;
    checks++;
    if (cpu_stall !== 1'b0 || dbg_ack !== 1'b0) begin
      errors++;
      $display("FAIL dbg_rd_entry: got stall=%b ack=%b, expected stall=0 ack=0", cpu_stall, dbg_ack);
    end
    @(negedge clk);
    #1;
    checks++;
    if (cpu_stall !== 1'b1 || dbg_ack !== 1'b0 || rs_ra1 !== 6'd7 || rs_we !== 1'b0) begin
      errors++;
      $display("FAIL dbg_rd_acc: got stall=%b ack=%b ra1=%0d we=%b, expected stall=1 ack=0 ra1=7 we=0",
               cpu_stall, dbg_ack, rs_ra1, rs_we);
    end
    @(negedge clk);
    #1;
    checks++;
    if (cpu_stall !== 1'b1 || dbg_ack !== 1'b1 || dbg_rdata !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL dbg_rd_rsp: got stall=%b ack=%b rdata=%h, expected stall=1 ack=1 rdata=a5a5a5a5",
               cpu_stall, dbg_ack, dbg_rdata);
    end
    dbg_req = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (cpu_stall !== 1'b0 || dbg_ack !== 1'b0 || cpu_rd1 !== 32'h33 || cpu_rd2 !== 32'h44) begin
      errors++;
      $display("FAIL dbg_rd_replay: got stall=%b ack=%b rd1=%h rd2=%h, expected stall=0 ack=0 rd1=33 rd2=44",
               cpu_stall, dbg_ack, cpu_rd1, cpu_rd2);
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] es = 7'b0110110;
    logic [6:0] ea = 7'b0100100;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 0) begin
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd5;
      end
      #1;
      checks++;
      if (cpu_stall !== es[i] || dbg_ack !== ea[i] || (ea[i] && dbg_rdata !== 32'hDEADBEEF)) begin
        errors++;
        $display("FAIL b2b[%0d]: got stall=%b ack=%b rdata=%h, expected stall=%b ack=%b rdata=deadbeef",
                 i, cpu_stall, dbg_ack, dbg_rdata, es[i], ea[i]);
      end
      if (i == 5) dbg_req = 1'b0;
    end
  endtask

  task automatic test_dbg_write;
    @(negedge clk);
    cpu_we = 1'b1; cpu_wa = 6'd9; cpu_wd = 32'h11; cpu_ra1 = 6'd9; cpu_ra2 = 6'd9;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd9; dbg_wdata = 32'h22;
    #1;
    checks++;
    if (rs_we !== 1'b1 || rs_wa !== 6'd9 || rs_wd !== 32'h11) begin
      errors++;
      $display("FAIL dbg_wr_cpu: got we=%b wa=%0d wd=%h, expected we=1 wa=9 wd=11", rs_we, rs_wa, rs_wd);
    end
    @(negedge clk);
    cpu_we = 1'b0;
    #1;
    checks++;
    if (rs_we !== 1'b1 || rs_wa !== 6'd9 || rs_wd !== 32'h22 || cpu_stall !== 1'b1) begin
      errors++;
      $display("FAIL dbg_wr_acc: got we=%b wa=%0d wd=%h stall=%b, expected we=1 wa=9 wd=22 stall=1",
               rs_we, rs_wa, rs_wd, cpu_stall);
    end
    @(negedge clk);
    #1;
    checks++;
    if (dbg_ack !== 1'b1 || dbg_rdata !== 32'h11) begin
      errors++;
      $display("FAIL dbg_wr_rsp: got ack=%b rdata=%h, expected ack=1 rdata=11", dbg_ack, dbg_rdata);
    end
    dbg_req = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (cpu_rd1 !== 32'h22 || cpu_rd2 !== 32'h22 || dbg_ack !== 1'b0) begin
      errors++;
      $display("FAIL dbg_wr_final: got rd1=%h rd2=%h ack=%b, expected rd1=22 rd2=22 ack=0", cpu_rd1, cpu_rd2, dbg_ack);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd7; dbg_wdata = 32'hFFFF;
    @(negedge clk);
    #1;
    checks++;
    if (cpu_stall !== 1'b1 || dbg_ack !== 1'b0 || rs_we !== 1'b1) begin
      errors++;
      $display("FAIL mid_acc: got stall=%b ack=%b we=%b, expected stall=1 ack=0 we=1", cpu_stall, dbg_ack, rs_we);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dbg_req = 1'b0;
    run_clear("mid");
    @(negedge clk);
    cpu_ra1 = 6'd7; cpu_ra2 = 6'd9;
    @(negedge clk);
    #1;
    checks++;
    if (cpu_rd1 !== 32'h0 || cpu_rd2 !== 32'h0 || dbg_ack !== 1'b0) begin
      errors++;
      $display("FAIL mid_cleared: got rd1=%h rd2=%h ack=%b, expected 0 0 0", cpu_rd1, cpu_rd2, dbg_ack);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_forward();
    test_x0();
    test_dbg_read();
    test_back_to_back();
    test_dbg_write();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
